// File: rtl/fxp_matmul_stream_pkg.sv
// fxp_matmul_pkg: shared types and helpers for the streaming fixed-point
// matrix multiplier.
//   state_t      : FSM encoding (IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT)
//   acc_width()  : derived accumulator width, 2*DATA_W + clog2(N)
//   round_narrow : round-half-up of a Q-format accumulator, then narrow to
//                  DATA_W. Clamps (and flags) when FXP_MATMUL_SAT_EN is
//                  defined, otherwise wraps (two's complement).
package fxp_matmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  // Conversion is done on a fixed wide signed container so the helper
  // does not depend on the block parameters; callers sign-extend into it.
  localparam int RN_W = 64;

  typedef struct packed {
    logic signed [RN_W-1:0] val;
    logic                   sat;
  } rn_t;

  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic rn_t round_narrow(input logic signed [RN_W-1:0] acc,
                                       input int frac_w,
                                       input int data_w);
    rn_t                    res;
    logic signed [RN_W-1:0] half;
    logic signed [RN_W-1:0] r;
`ifdef FXP_MATMUL_SAT_EN
    logic signed [RN_W-1:0] lo;
    logic signed [RN_W-1:0] hi;
`endif
    half = 64'sd1 <<< (frac_w - 1);
    r    = (acc + half) >>> frac_w;
`ifdef FXP_MATMUL_SAT_EN
    lo = -(64'sd1 <<< (data_w - 1));
    hi = ~lo;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
`else
    // keep the low data_w bits, sign-extended back into the container
    res.val = (r <<< (RN_W - data_w)) >>> (RN_W - data_w);
    res.sat = 1'b0;
`endif
    return res;
  endfunction

endpackage

// File: rtl/fxp_matmul_stream_if.sv
// fxp_matmul_stream_if: input and output valid/ready element streams of the
// matrix multiplier.
//   in_valid/in_ready/in_data     : A then B elements, row-major
//   out_valid/out_ready/out_data  : C elements, row-major
//   out_last                      : marks C[N-1][N-1]
// master = host/sink side, slave = multiplier side.
interface fxp_matmul_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fxp_matmul_stream_mac.sv
// fxp_mac: registered signed multiply-accumulate.
//   clk, reset_n : clock, async active-low reset
//   i_en         : update the accumulator this cycle
//   i_clr        : start a new sum (the product replaces the old value)
//   i_a, i_b     : signed DATA_W operands
//   o_sum        : value the accumulator takes on this edge when enabled,
//                  i.e. the sum including the current product. Exposed so
//                  the caller can convert a finished dot product without
//                  waiting an extra cycle.
module fxp_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_sum
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_x;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod   = i_a * i_b;
  assign w_prod_x = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign o_sum    = (i_clr ? '0 : r_acc) + w_prod_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_acc <= '0;
    else if (i_en) r_acc <= o_sum;
  end
endmodule

// File: rtl/fxp_matmul_stream.sv
// fxp_matmul_stream: streaming signed fixed-point C = A x B for NxN matrices.
//   clk, reset_n : clock, async active-low reset (aborts any operation)
//   bus (slave)  : input stream of A then B (row-major), output stream of C
//                  (row-major) with out_last on C[N-1][N-1]
//   busy         : FSM not in IDLE
//   sat_flag     : some element of the current result clipped; cleared on the
//                  first accepted beat of the next matrix
// Optional feature macro: FXP_MATMUL_SAT_EN (saturate instead of wrap).
// One MAC per cycle; COMPUTE takes N^3 cycles and C is written at k=N-1.
module fxp_matmul_stream
  import fxp_matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fxp_matmul_stream_if.slave   bus,
  output logic                 busy,
  output logic                 sat_flag
);
  localparam int ACC_W = acc_width(N, DATA_W);
  localparam int NN    = N * N;
  localparam int IW    = $clog2(NN);
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] LAST_N  = CW'(N - 1);
  localparam logic [IW-1:0] LAST_NN = IW'(NN - 1);

  state_t                    r_state;
  logic [IW-1:0]             r_ld_cnt;
  logic [CW-1:0]             r_i, r_j, r_k;
  logic [IW-1:0]             r_oidx;
  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_out_data;
  logic                      r_out_last;
  logic                      r_sat;

  logic signed [DATA_W-1:0]  r_a [NN];
  logic signed [DATA_W-1:0]  r_b [NN];
  logic signed [DATA_W-1:0]  r_c [NN];

  logic                      w_in_ready;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_mac_en;
  logic                      w_k_last;
  logic [IW-1:0]             w_aidx, w_bidx, w_cidx, w_onext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [RN_W-1:0]    w_sum64;
  rn_t                       w_rn;
  logic                      w_unused_rn_hi;

  // gated by reset_n so in_ready reads 0 while reset is held
  assign w_in_ready = reset_n &&
                      (r_state == IDLE || r_state == LOAD_A || r_state == LOAD_B);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_mac_en   = (r_state == COMPUTE);
  assign w_k_last   = (r_k == LAST_N);

  assign w_aidx  = IW'(int'(r_i) * N + int'(r_k));
  assign w_bidx  = IW'(int'(r_k) * N + int'(r_j));
  assign w_cidx  = IW'(int'(r_i) * N + int'(r_j));
  assign w_onext = r_oidx + IW'(1);

  fxp_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_mac_en),
    .i_clr   (r_k == '0),
    .i_a     (r_a[w_aidx]),
    .i_b     (r_b[w_bidx]),
    .o_sum   (w_sum)
  );

  assign w_sum64        = {{(RN_W-ACC_W){w_sum[ACC_W-1]}}, w_sum};
  assign w_rn           = round_narrow(w_sum64, FRAC_W, DATA_W);
  assign w_unused_rn_hi = ^w_rn.val[RN_W-1:DATA_W];

  // Operand/result storage: no reset needed, contents are always rewritten
  // before use; an aborted load simply leaves stale data that is overwritten.
  always_ff @(posedge clk) begin
    if (w_in_fire && r_state != LOAD_B) r_a[r_ld_cnt] <= bus.in_data;
    if (w_in_fire && r_state == LOAD_B) r_b[r_ld_cnt] <= bus.in_data;
    if (w_mac_en && w_k_last)           r_c[w_cidx]   <= w_rn.val[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ld_cnt    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_oidx      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_ld_cnt <= IW'(1);
            r_sat    <= 1'b0;
            r_state  <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (w_in_fire) begin
            if (r_ld_cnt == LAST_NN) begin
              r_ld_cnt <= '0;
              r_state  <= LOAD_B;
            end else begin
              r_ld_cnt <= r_ld_cnt + IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_in_fire) begin
            if (r_ld_cnt == LAST_NN) begin
              r_ld_cnt <= '0;
              r_i      <= '0;
              r_j      <= '0;
              r_k      <= '0;
              r_state  <= COMPUTE;
            end else begin
              r_ld_cnt <= r_ld_cnt + IW'(1);
            end
          end
        end
        COMPUTE: begin
          if (w_k_last) begin
            r_k   <= '0;
            r_sat <= r_sat | w_rn.sat;
            if (r_j == LAST_N) begin
              r_j <= '0;
              if (r_i == LAST_N) begin
                // C[N-1][N-1] lands this edge; C[0][0] was written long ago
                r_i         <= '0;
                r_oidx      <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= r_c[0];
                r_out_last  <= 1'b0;
                r_state     <= OUTPUT;
              end else begin
                r_i <= r_i + CW'(1);
              end
            end else begin
              r_j <= r_j + CW'(1);
            end
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        OUTPUT: begin
          if (w_out_fire) begin
            if (r_oidx == LAST_NN) begin
              r_oidx      <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_oidx     <= w_onext;
              r_out_data <= r_c[w_onext];
              r_out_last <= (w_onext == LAST_NN);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state != IDLE);
  // without saturation w_rn.sat is constant 0, so this is tied low
  assign sat_flag      = r_sat;

endmodule

// File: tb/tb_fxp_matmul_stream.sv
`timescale 1ns/1ps
module tb_fxp_matmul_stream;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fxp_matmul_stream_if #(.DATA_W(8))  bus1();
  fxp_matmul_stream_if #(.DATA_W(16)) bus2();
  logic busy1, sat1, busy2, sat2;

  fxp_matmul_stream #(.N(4), .DATA_W(8), .FRAC_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .busy(busy1), .sat_flag(sat1));
  fxp_matmul_stream #(.N(2), .DATA_W(16), .FRAC_W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .busy(busy2), .sat_flag(sat2));

  assign bus2.out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [15:0] d; logic l; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  // out_ready for DUT1: constant high or 50% random, changed just after posedge
  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    bus1.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // DUT1 monitor: pops the scoreboard on each handshake, checks stall stability
  logic       stall1 = 1'b0;
  logic [7:0] hold_d1;
  logic       hold_l1;
  exp_t       e1;
  always @(negedge clk) begin
    if (!reset_n) stall1 = 1'b0;
    else begin
      if (stall1) begin
        check("stall_data", 64'(bus1.out_data), 64'(hold_d1));
        check("stall_last", 64'(bus1.out_last), 64'(hold_l1));
      end
      if (bus1.out_valid) begin
        check("in_ready_low_output", 64'(bus1.in_ready), 0);
        if (bus1.out_ready) begin
          if (q1.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e1 = q1.pop_front();
            check("c_data", 64'(bus1.out_data), 64'(e1.d[7:0]));
            check("c_last", 64'(bus1.out_last), 64'(e1.l));
          end
        end
      end
      stall1  = bus1.out_valid && !bus1.out_ready;
      hold_d1 = bus1.out_data;
      hold_l1 = bus1.out_last;
    end
  end

  exp_t e2;
  always @(negedge clk) begin
    if (reset_n && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) check("n2_unexpected_output", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("n2_c_data", 64'(bus2.out_data), 64'(e2.d));
        check("n2_c_last", 64'(bus2.out_last), 64'(e2.l));
      end
    end
  end

  int ma[16], mb[16], mc[16];

  // Independent reference: exact integer dot product, half-up round, narrow.
  function automatic void model();
    longint acc, r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(ma[i*4+k]) * longint'(mb[k*4+j]);
        r = (acc + 8) >>> 4;
`ifdef FXP_MATMUL_SAT_EN
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
`endif
        mc[i*4+j] = int'(r);
      end
  endfunction

  task automatic push1();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.d = 16'(8'(mc[i]));
      e.l = (i == 15);
      q1.push_back(e);
    end
  endtask

  task automatic send1(input int v);
    int n = 0;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'(v);
    while (!bus1.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus1.in_ready) check("in_ready_timeout", 0, 1);
    else @(posedge clk);
    #1 bus1.in_valid = 1'b0;
  endtask

  task automatic send2(input int v);
    int n = 0;
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 16'(v);
    while (!bus2.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus2.in_ready) check("n2_in_ready_timeout", 0, 1);
    else @(posedge clk);
    #1 bus2.in_valid = 1'b0;
  endtask

  task automatic load1(output int t_acc);
    for (int i = 0; i < 16; i++) send1(ma[i]);
    for (int i = 0; i < 16; i++) send1(mb[i]);
    t_acc = cyc;
  endtask

  task automatic run1(input bit measure);
    int t_acc, n;
    bit bad;
    load1(t_acc);
    n = 0; bad = 0;
    @(negedge clk);
    while (!bus1.out_valid && n < 1000) begin
      if (bus1.in_ready || !busy1) bad = 1;
      @(negedge clk); n++;
    end
    check("out_valid_timeout", 64'(bus1.out_valid), 1);
    check("in_ready_low_compute", 64'(bad), 0);
    if (measure) check("latency", cyc - t_acc + 1, 65);
    n = 0;
    while ((q1.size() != 0 || bus1.out_valid) && n < 3000) begin @(negedge clk); n++; end
    check("drain", q1.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  64'(bus1.in_ready), 0);
    check({tag, "_out_valid"}, 64'(bus1.out_valid), 0);
    check({tag, "_out_data"},  64'(bus1.out_data), 0);
    check({tag, "_out_last"},  64'(bus1.out_last), 0);
    check({tag, "_busy"},      64'(busy1), 0);
    check({tag, "_sat"},       64'(sat1), 0);
  endtask

  task automatic set_ident_b(input int base, input int step);
    for (int i = 0; i < 16; i++) begin
      ma[i] = (i % 5 == 0) ? 16 : 0;   // diagonal of a 4x4 = 1.0
      mb[i] = base + step * i;
      mc[i] = mb[i];                  // I x B = B exactly
    end
  endtask

  initial begin
    int t_dummy;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    bus2.in_valid = 1'b0; bus2.in_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    #1 check("in_ready_after_release", 64'(bus1.in_ready), 1);

    // identity x B[r][c] = r*4+c
    set_ident_b(0, 1);
    push1();
    run1(1'b1);

    // all 1.0 x all 2.0 -> 8.0 overflows Q4.4
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16; mb[i] = 32;
`ifdef FXP_MATMUL_SAT_EN
      mc[i] = 127;
`else
      mc[i] = -128;
`endif
    end
    push1();
    run1(1'b0);
`ifdef FXP_MATMUL_SAT_EN
    check("sat_flag_set", 64'(sat1), 1);
`else
    check("sat_flag_tied", 64'(sat1), 0);
`endif

    // rounding: 1/16 * 8/16 = 0.03125 -> rounds up to 1 LSB
    for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    ma[0] = 1; mb[0] = 8; mc[0] = 1;
    push1();
    run1(1'b0);
    check("sat_flag_cleared", 64'(sat1), 0);
    // -0.03125 -> rounds half-up to 0
    ma[0] = -1; mc[0] = 0;
    push1();
    run1(1'b0);

    // random operands, random backpressure
    for (int i = 0; i < 16; i++) begin
      ma[i] = int'($urandom_range(0, 255)) - 128;
      mb[i] = int'($urandom_range(0, 255)) - 128;
    end
    model();
    push1();
    rnd_ready = 1'b1;
    run1(1'b0);
    rnd_ready = 1'b0;

    // reset mid-COMPUTE: nothing queued, so any emitted element is stale
    set_ident_b(100, -3);
    load1(t_dummy);
    repeat (20) @(negedge clk);
    check("busy_before_abort", 64'(busy1), 1);
    reset_n = 1'b0;
    #2 check_reset_vals("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("in_ready_after_abort", 64'(bus1.in_ready), 1);
    set_ident_b(-8, 5);
    push1();
    run1(1'b1);

    // N=2, Q8.8 build
    begin
      int a2[4] = '{256, 512, 0, 256};
      int b2[4] = '{256, 0, 256, 256};
      int c2[4] = '{768, 512, 256, 256};
      int n = 0;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
        e.d = 16'(c2[i]); e.l = (i == 3); q2.push_back(e);
      end
      for (int i = 0; i < 4; i++) send2(a2[i]);
      for (int i = 0; i < 4; i++) send2(b2[i]);
      while ((q2.size() != 0 || bus2.out_valid) && n < 500) begin @(negedge clk); n++; end
      check("n2_drain", q2.size(), 0);
      check("n2_busy_idle", 64'(busy2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
